branch_predictor: RTL and testbench

- Fetch-side dynamic branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Fetch sends it the fetch PC each cycle and gets back, in the same cycle, a taken/not-taken prediction and the next PC. Fetch carries these forward as its branch prediction to the pipeline controller's hazard/miss logic.
- The stage where the branch outcome is confirmed (execute, or memory-access in BRANCH_M builds) trains the predictor through a single update port.

---
 rtl/branch_predictor_if.sv | 29 ++
 rtl/branch_predictor.sv | 83 ++++++++
 tb/tb_branch_predictor.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/train bundle for the branch predictor.
// Handshake: no valid/ready pair here. Lookup has no handshake at all:
// fetchPc is a plain input and predictTaken/predictTarget are combinational
// answers for the current cycle. updateValid qualifies the update fields.
// An update is consumed at the rising clock edge where updateValid is high.
// The predictor cannot refuse or stall an update.
interface branch_predictor_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] fetchPc;
  logic                predictTaken;
  logic [PC_WIDTH-1:0] predictTarget;
  logic                updateValid;
  logic [PC_WIDTH-1:0] updatePc;
  logic                updateTaken;
  logic [PC_WIDTH-1:0] updateTarget;

  // Fetch/execute side: drives lookup PCs and resolved branch outcomes.
  modport master (
    output fetchPc, updateValid, updatePc, updateTaken, updateTarget,
    input  predictTaken, predictTarget
  );

  // Predictor side.
  modport slave (
    input  fetchPc, updateValid, updatePc, updateTaken, updateTarget,
    output predictTaken, predictTarget
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Lookup is an asynchronous read of the current table state, so a same-cycle
// update at the same index is not bypassed to the lookup.
// Only the valid bits are reset. tag, target and ctr are don't-care until
// their entry is allocated.
module branch_predictor #(
  parameter int PC_WIDTH  = 32,
  parameter int ENTRY_NUM = 16
) (
  input logic                clk,
  input logic                rst,
  branch_predictor_if.slave  bp_if
);
  localparam int IW = $clog2(ENTRY_NUM);
  localparam int TW = PC_WIDTH - IW - 2;

  logic [ENTRY_NUM-1:0] r_valid;
  logic [TW-1:0]        r_tag    [ENTRY_NUM];
  logic [PC_WIDTH-1:0]  r_target [ENTRY_NUM];
  logic [1:0]           r_ctr    [ENTRY_NUM];

  logic [IW-1:0] w_fetch_idx;
  logic [TW-1:0] w_fetch_tag;
  logic          w_fetch_hit;
  logic [IW-1:0] w_upd_idx;
  logic [TW-1:0] w_upd_tag;
  logic          w_upd_hit;
  logic [1:0]    w_ctr_inc;
  logic [1:0]    w_ctr_dec;
  logic          w_unused_low_bits;

  // PC bits [1:0] do not take part in the index or the tag.
  assign w_unused_low_bits = &{1'b0, bp_if.fetchPc[1:0], bp_if.updatePc[1:0]};

  assign w_fetch_idx = bp_if.fetchPc[IW+1:2];
  assign w_fetch_tag = bp_if.fetchPc[PC_WIDTH-1:IW+2];
  assign w_upd_idx   = bp_if.updatePc[IW+1:2];
  assign w_upd_tag   = bp_if.updatePc[PC_WIDTH-1:IW+2];

  // Lookup: predict taken only on a tag hit whose counter is in a taken state.
  always_comb begin
    w_fetch_hit         = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
    bp_if.predictTaken  = w_fetch_hit && r_ctr[w_fetch_idx][1];
    bp_if.predictTarget = bp_if.predictTaken ? r_target[w_fetch_idx]
                                             : bp_if.fetchPc + PC_WIDTH'(4);
  end

  // Update-side hit detection and saturating counter steps.
  always_comb begin
    w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    w_ctr_inc = (r_ctr[w_upd_idx] == 2'b11) ? 2'b11 : r_ctr[w_upd_idx] + 2'b01;
    w_ctr_dec = (r_ctr[w_upd_idx] == 2'b00) ? 2'b00 : r_ctr[w_upd_idx] - 2'b01;
  end

  // Valid bits: cleared by reset (which also drops any update that cycle);
  // set on a taken miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (bp_if.updateValid && bp_if.updateTaken && !w_upd_hit) begin
      r_valid[w_upd_idx] <= 1'b1;
    end
  end

  // Entry payload: train on a hit, allocate on a taken miss.
  // A not-taken miss leaves any aliasing entry alone.
  always_ff @(posedge clk) begin
    if (!rst && bp_if.updateValid) begin
      if (w_upd_hit) begin
        if (bp_if.updateTaken) begin
          r_ctr[w_upd_idx]    <= w_ctr_inc;
          r_target[w_upd_idx] <= bp_if.updateTarget;
        end else begin
          r_ctr[w_upd_idx]    <= w_ctr_dec;
        end
      end else if (bp_if.updateTaken) begin
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= bp_if.updateTarget;
        r_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios followed by random traffic.
// A reference table keyed by entry number supplies the expected lookups.
module tb_branch_predictor;
  localparam int PC_WIDTH = 32;
  localparam int ENTRIES  = 16;
  localparam int W        = PC_WIDTH + 1;

  logic clk;
  logic rst;

  branch_predictor_if #(.PC_WIDTH(PC_WIDTH)) bus ();

  branch_predictor #(.PC_WIDTH(PC_WIDTH), .ENTRY_NUM(ENTRIES)) dut (
    .clk   (clk),
    .rst   (rst),
    .bp_if (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  int unsigned m_target [ENTRIES];
  int          m_ctr    [ENTRIES];

  function automatic int unsigned idx_of(input int unsigned pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic logic [W-1:0] model_predict(input int unsigned pc);
    int unsigned i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2)
      return {1'b1, m_target[i]};
    return {1'b0, 32'(pc + 4)};
  endfunction

  task automatic model_update(input bit r, input bit uv, input int unsigned upc,
                              input bit ut, input int unsigned utgt);
    int unsigned i;
    if (r) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      i = idx_of(upc);
      if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
        if (ut) begin
          m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_target[i] = utgt;
        end else begin
          m_ctr[i]    = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upc);
        m_target[i] = utgt;
        m_ctr[i]    = 2;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0]        exp_q [$];
  logic [PC_WIDTH-1:0] pc_q  [$];
  int n_compared   = 0;
  int n_mismatched = 0;

  // ---------------- driver ----------------
  // One cycle: drive at negedge, queue the expected lookup for the
  // pre-edge table, then advance the model at the posedge.
  task automatic step(input int unsigned fpc, input bit r, input bit uv,
                      input int unsigned upc, input bit ut, input int unsigned utgt);
    @(negedge clk);
    rst              = r;
    bus.fetchPc      = fpc;
    bus.updateValid  = uv;
    bus.updatePc     = upc;
    bus.updateTaken  = ut;
    bus.updateTarget = utgt;
    exp_q.push_back(model_predict(fpc));
    pc_q.push_back(fpc);
    @(posedge clk);
    model_update(r, uv, upc, ut, utgt);
  endtask

  task automatic look(input int unsigned fpc);
    step(fpc, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic upd(input int unsigned fpc, input int unsigned upc,
                     input bit ut, input int unsigned utgt);
    step(fpc, 1'b0, 1'b1, upc, ut, utgt);
  endtask

  task automatic do_reset();
    step(32'h100, 1'b1, 1'b0, 0, 1'b0, 0);
    step(32'h100, 1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  // ---------------- monitor ----------------
  // Outputs are combinational; sample mid-cycle, well after the negedge drive.
  initial begin
    logic [W-1:0]        exp_v;
    logic [W-1:0]        act_v;
    logic [PC_WIDTH-1:0] pc_v;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        pc_v  = pc_q.pop_front();
        act_v = {bus.predictTaken, bus.predictTarget};
        n_compared++;
        if (act_v !== exp_v) begin
          n_mismatched++;
          $display("FAIL lookup pc=%h: got taken=%0b target=%h, expected taken=%0b target=%h",
                   pc_v, act_v[W-1], act_v[PC_WIDTH-1:0], exp_v[W-1], exp_v[PC_WIDTH-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned uppers [3];
    int unsigned fpc, upc, tgt;
    rst = 1'b1;
    bus.fetchPc = '0; bus.updateValid = 1'b0; bus.updatePc = '0;
    bus.updateTaken = 1'b0; bus.updateTarget = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      m_valid[k] = 1'b0; m_tag[k] = 0; m_target[k] = 0; m_ctr[k] = 0;
    end

    // Cold start, including PC wrap.
    do_reset();
    look(32'h100);
    look(32'hFFFF_FFFC);

    // Allocation: same-cycle lookup sees the old state.
    upd(32'h100, 32'h100, 1'b1, 32'h200);
    look(32'h100);

    // Training down, saturation at 00, one taken back to 01.
    upd(32'h100, 32'h100, 1'b0, 0);
    look(32'h100);
    upd(32'h100, 32'h100, 1'b0, 0);
    upd(32'h100, 32'h100, 1'b0, 0);
    upd(32'h100, 32'h100, 1'b1, 32'h200);
    look(32'h100);

    // Saturation at 11 and hysteresis; target refresh.
    do_reset();
    for (int k = 0; k < 3; k++) upd(32'h100, 32'h100, 1'b1, 32'h200);
    upd(32'h100, 32'h100, 1'b0, 0);
    look(32'h100);
    upd(32'h100, 32'h100, 1'b1, 32'h300);
    look(32'h100);

    // Aliasing at index 0.
    do_reset();
    upd(32'h100, 32'h100, 1'b1, 32'h200);
    look(32'h140);
    upd(32'h140, 32'h140, 1'b0, 0);
    look(32'h100);
    upd(32'h140, 32'h140, 1'b1, 32'h400);
    look(32'h140);
    look(32'h100);

    // Reset mid-operation drops a concurrent update.
    upd(32'h100, 32'h100, 1'b1, 32'h200);
    upd(32'h108, 32'h108, 1'b1, 32'h208);
    look(32'h108);
    step(32'h110, 1'b1, 1'b1, 32'h110, 1'b1, 32'h500);
    look(32'h100);
    look(32'h108);
    look(32'h110);

    // Random traffic over a few aliasing tags so hits and conflicts occur.
    uppers[0] = 32'h0000_0100; uppers[1] = 32'h0000_0140; uppers[2] = 32'hFFFF_FFC0;
    for (int n = 0; n < 600; n++) begin
      fpc = uppers[$urandom_range(0, 2)] + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      upc = uppers[$urandom_range(0, 2)] + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      tgt = $urandom();
      step(fpc, ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
           upc, ($urandom_range(0, 2) != 0), tgt);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
